// File: rtl/ser_link_tx_framer.sv
// ser_link_tx_framer
// Transmit-side framer for the 4-lane DDR serial link. Accepts parallel flits
// and emits one header beat, FlitWidth/8 data beats (LSB byte first) and an
// optional CRC-8 beat. Each beat is a rising-phase and a falling-phase nibble.
// Credit-based flow control: one credit per accepted flit, returned by
// single-cycle credit pulses from the far-end receiver.
//
// Build option:
//   SER_LINK_TX_CRC8_EN  when defined, a CRC-8 beat (poly 0x07, init 0x00,
//                        MSB first, no final XOR) closes every frame.
//
// Ports:
//   clk_i         core clock
//   rst_i         asynchronous active-high reset
//   flit_i        flit payload
//   flit_valid_i  payload valid
//   flit_ready_o  payload accepted when valid and ready are both high
//   credit_i      single-cycle pulse, receiver freed one buffer
//   ddr_pos_o     rising-phase nibble, bit i drives lane i
//   ddr_neg_o     falling-phase nibble, bit i drives lane i
//   ddr_clk_en_o  forwarded-clock enable, high on every non-idle beat
//   credits_o     current credit count
//   credit_ovf_o  sticky, credit returned while already at MaxCredits
module ser_link_tx_framer #(
  parameter int unsigned FlitWidth  = 64,
  parameter int unsigned MaxCredits = 8
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic [FlitWidth-1:0]               flit_i,
  input  logic                               flit_valid_i,
  output logic                               flit_ready_o,
  input  logic                               credit_i,
  output logic [3:0]                         ddr_pos_o,
  output logic [3:0]                         ddr_neg_o,
  output logic                               ddr_clk_en_o,
  output logic [$clog2(MaxCredits+1)-1:0]    credits_o,
  output logic                               credit_ovf_o
);

  localparam int unsigned NB    = FlitWidth / 8;
  localparam int unsigned CntW  = (NB > 1) ? $clog2(NB) : 1;
  localparam int unsigned CredW = $clog2(MaxCredits + 1);

  localparam logic [3:0] HdrPos = 4'hA;
  localparam logic [3:0] HdrNeg = 4'h5;

  typedef enum logic [1:0] {
    S_IDLE,
    S_HDR,
`ifdef SER_LINK_TX_CRC8_EN
    S_DATA,
    S_CRC
`else
    S_DATA
`endif
  } state_t;

  state_t               state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [FlitWidth-1:0] sh_q, sh_d;
  logic [3:0]           pos_q, pos_d;
  logic [3:0]           neg_q, neg_d;
  logic                 en_q, en_d;
  logic [CredW-1:0]     cred_q;
  logic                 ovf_q;
  logic                 last_c;
  logic                 accept_c;
  logic                 final_data_c;

`ifdef SER_LINK_TX_CRC8_EN
  logic [7:0]           crc_q, crc_d;

  // One byte of CRC-8 (poly 0x07), MSB first.
  function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] r;
    r = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
    end
    return r;
  endfunction
`endif

  assign final_data_c = (state_q == S_DATA) && (cnt_q == CntW'(NB - 1));

  // The beat currently being prepared is the last of its frame.
`ifdef SER_LINK_TX_CRC8_EN
  assign last_c = (state_q == S_CRC);
`else
  assign last_c = final_data_c;
`endif

  // Ready depends on registered state and credits only.
  assign flit_ready_o = ((state_q == S_IDLE) || last_c) && (cred_q != '0);
  assign accept_c     = flit_valid_i && flit_ready_o;

  // Next-state, payload shifter and next beat.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    pos_d   = 4'h0;
    neg_d   = 4'h0;
    en_d    = 1'b0;
`ifdef SER_LINK_TX_CRC8_EN
    crc_d   = crc_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (accept_c) state_d = S_HDR;
      end

      S_HDR: begin
        pos_d   = HdrPos;
        neg_d   = HdrNeg;
        en_d    = 1'b1;
        cnt_d   = '0;
        state_d = S_DATA;
`ifdef SER_LINK_TX_CRC8_EN
        crc_d   = 8'h00;
`endif
      end

      S_DATA: begin
        // Low byte of the shifter is the byte on the wire this beat.
        pos_d = sh_q[3:0];
        neg_d = sh_q[7:4];
        en_d  = 1'b1;
        sh_d  = sh_q >> 8;
`ifdef SER_LINK_TX_CRC8_EN
        crc_d = crc8_byte(crc_q, sh_q[7:0]);
`endif
        if (final_data_c) begin
`ifdef SER_LINK_TX_CRC8_EN
          state_d = S_CRC;
`else
          state_d = accept_c ? S_HDR : S_IDLE;
`endif
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

`ifdef SER_LINK_TX_CRC8_EN
      S_CRC: begin
        pos_d   = crc_q[3:0];
        neg_d   = crc_q[7:4];
        en_d    = 1'b1;
        state_d = accept_c ? S_HDR : S_IDLE;
      end
`endif

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Capture overrides the shift; accept only happens in IDLE or the last beat.
    if (accept_c) sh_d = flit_i;
  end

  // State, payload and registered lane outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      pos_q   <= 4'h0;
      neg_q   <= 4'h0;
      en_q    <= 1'b0;
`ifdef SER_LINK_TX_CRC8_EN
      crc_q   <= 8'h00;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      pos_q   <= pos_d;
      neg_q   <= neg_d;
      en_q    <= en_d;
`ifdef SER_LINK_TX_CRC8_EN
      crc_q   <= crc_d;
`endif
    end
  end

  // Credit counter; simultaneous accept and credit cancel out.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cred_q <= CredW'(MaxCredits);
      ovf_q  <= 1'b0;
    end else if (accept_c && !credit_i) begin
      cred_q <= cred_q - CredW'(1);
    end else if (!accept_c && credit_i) begin
      if (cred_q == CredW'(MaxCredits)) begin
        ovf_q <= 1'b1;
      end else begin
        cred_q <= cred_q + CredW'(1);
      end
    end
  end

  assign ddr_pos_o    = pos_q;
  assign ddr_neg_o    = neg_q;
  assign ddr_clk_en_o = en_q;
  assign credits_o    = cred_q;
  assign credit_ovf_o = ovf_q;

endmodule

// File: doc/ser_link_tx_framer.md
# ser_link_tx_framer

Transmit-side framer for the 4-lane DDR serial link; it drives the `ser_link_to_pad` lanes (`ddr0_o`..`ddr3_o`) plus a forwarded-clock enable. It accepts parallel flits from the SoC-side AXI-to-link bridge and emits framed beats as rising- and falling-phase nibbles per core clock. The pad-level DDR output mux sits outside this block. Credit-based flow control is closed by credit pulses returned from the far-end receiver.

## Interface
- `FlitWidth`, 64: flit payload bits; must be a multiple of 8, minimum 8.
- `MaxCredits`, 8: receiver buffer depth in flits; reset value of the credit counter.
- `clk_i`  in  1  core clock.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `flit_i`  in  FlitWidth  payload.
- `flit_valid_i`  in  1  payload valid.
- `flit_ready_o`  out  1  payload accepted when valid and ready are both high.
- `credit_i`  in  1  single-cycle pulse; the receiver freed one buffer.
- `ddr_pos_o`  out  4  nibble for the rising phase; bit i drives lane i.
- `ddr_neg_o`  out  4  nibble for the falling phase; bit i drives lane i.
- `ddr_clk_en_o`  out  1  forwarded-clock enable; high on every non-idle beat.
- `credits_o`  out  $clog2(MaxCredits+1)  current credit count.
- `credit_ovf_o`  out  1  sticky; set when a credit arrives while the count is already at MaxCredits.

## Operation
- **Frame layout:**
  - One header beat: pos=4'hA, neg=4'h5.
  - NB=FlitWidth/8 data beats.
  - Optional CRC beat (see Configuration).
- **Data beat k** carries byte `flit[8k+7:8k]`, LSB byte first: pos = low nibble, neg = high nibble.
- **FSM states:**
  - IDLE: outputs 0, `ddr_clk_en_o`=0.
  - HDR.
  - DATA: beat counter 0..NB-1.
  - CRC: only when compiled in.
  - LAST is the final beat of the frame, i.e. DATA with count NB-1, or CRC.
- **FSM transitions:**
  - IDLE→HDR on accept.
  - HDR→DATA.
  - DATA→DATA while count < NB-1.
  - Final data beat → CRC (if enabled) or end of frame.
  - End of frame → HDR if accepting this cycle, else IDLE.
- **Ready and payload capture:**
  - `flit_ready_o` = (state==IDLE or LAST beat) and credits>0. It is combinational from registered state only and has no dependency on `flit_valid_i`.
  - The flit is captured into an internal register on accept. The input may change afterwards.
- **Credits:**
  - Decrement on accept; increment on `credit_i`.
  - Both in the same cycle: count is unchanged.
  - `credit_i` at MaxCredits with no simultaneous accept: count holds and `credit_ovf_o` is set. Only reset clears it.
  - Count never goes below 0, because ready is gated by credits>0.
- **Reset values:**
  - State IDLE; credits=MaxCredits.
  - All outputs 0, except `credits_o`=MaxCredits and `flit_ready_o`=1.
- **Reset mid-frame:** frame abandoned, lanes 0 in the first cycle after assertion, credits restored to MaxCredits. The receiver discards partial frames on header loss.

## Timing
- All lane outputs and `ddr_clk_en_o` are registered.
- Accept at edge N: header visible after edge N+1; data beat k after edge N+2+k; CRC (if enabled) after edge N+2+NB.
- Frame length: NB+1 beats without CRC, NB+2 beats with CRC. The 64-bit default gives 9 or 10.
- Back-to-back: an accept on the LAST beat puts the next header on the cycle immediately after, with no idle gap.
- `credits_o` updates one cycle after the accept or credit edge.

## Configuration
- `SER_LINK_TX_CRC8_EN`
  - Defined: a CRC beat follows the data beats. CRC-8, poly 0x07, init 0x00, no reflection, no final XOR, computed over data bytes in transmit order. CRC beat: pos = crc[3:0], neg = crc[7:4].
  - Undefined: no CRC state or logic; frame ends after data beat NB-1.
  - The far-end receiver must be built with the same setting.

## Test plan
- Single flit 0x0123_4567_89AB_CDEF, credits 8:
  - Header A/5, then pos/neg beats F/E, D/C, B/A, 9/8, 7/6, 5/4, 3/2, 1/0.
  - `ddr_clk_en_o` high for exactly 9 cycles (10 with CRC).
  - `credits_o`=7.
- Three flits with valid held high:
  - Headers at beats 0, 9, 18, with no idle beats between frames (0, 10, 20 with CRC).
  - `credits_o`=5.
- No credits returned after 8 flits:
  - `flit_ready_o`=0 and lanes idle.
  - One `credit_i` pulse: ready rises the next cycle and the 9th flit is sent.
- At credits=3, accept and `credit_i` in the same cycle:
  - `credits_o` stays 3.
  - A `credit_i` at credits=8 sets `credit_ovf_o`=1, which holds until reset.
- Assert `rst_i` during data beat 4:
  - Next cycle lanes=0, `ddr_clk_en_o`=0, `credits_o`=8.
  - The next flit starts with a fresh header.
- With `SER_LINK_TX_CRC8_EN`:
  - An all-zero flit gives CRC beat 0/0.
  - 1000 random flits match the CRC-8 model byte for byte.
